bcd_serial_subtractor: RTL and testbench

Digit-serial multi-digit BCD subtractor for the calculator datapath, the subtraction counterpart of the adder chain. It computes |A − B| with a sign flag, one BCD digit per clock, least-significant digit first. A second complement pass is run only when the result is negative. Operands are latched on a start pulse, and the result is presented with a one-cycle `done` pulse.

---
 rtl/bcd_serial_subtractor.sv | 137 +++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: |A - B| with sign, one digit per clock, LSD first.
// Negative results get a second ten's-complement pass over the work register.
module bcd_serial_subtractor #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                invalid
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StSub, StComp, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic            neg_q, neg_d, invalid_q, invalid_d;
    logic [3:0]      x, y;
    logic [4:0]      step;
    logic            last;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Returns {borrow_out, digit}; negative 4-bit result is corrected by +10.
    function automatic logic [4:0] digit_sub(input logic [3:0] p, input logic [3:0] q,
                                             input logic bin);
        logic [4:0] t;
        t = {1'b0, p} - {1'b0, q} - {4'b0, bin};
        if (t[4]) return {1'b1, t[3:0] + 4'd10};
        return {1'b0, t[3:0]};
    endfunction

    // COMP reuses the same digit step with a zero minuend and r as subtrahend.
    assign x    = (state_q == StSub) ? a_q[idx_q*4 +: 4] : 4'd0;
    assign y    = (state_q == StSub) ? b_q[idx_q*4 +: 4] : r_q[idx_q*4 +: 4];
    assign step = digit_sub(x, y, borrow_q);
    assign last = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        diff_d    = diff_q;
        neg_d     = neg_q;
        invalid_d = invalid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    r_d      = '0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (has_bad(a) || has_bad(b)) begin
                        invalid_d = 1'b1;
                        diff_d    = '0;
                        neg_d     = 1'b0;
                        state_d   = StDone;
                    end else begin
                        state_d = StSub;
                    end
                end
            end
            StSub, StComp: begin
                r_d[idx_q*4 +: 4] = step[3:0];
                borrow_d          = step[4];
                idx_d             = idx_q + IW'(1);
                if (last) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (state_q == StSub && step[4]) begin
                        state_d = StComp;
                    end else begin
                        diff_d    = r_d;
                        neg_d     = (state_q == StComp);
                        invalid_d = 1'b0;
                        state_d   = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            idx_q     <= '0;
            borrow_q  <= 1'b0;
            diff_q    <= '0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            diff_q    <= diff_d;
            neg_q     <= neg_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q == StSub) || (state_q == StComp);
    assign done    = (state_q == StDone);
    assign diff    = diff_q;
    assign neg     = neg_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed-vector bench for bcd_serial_subtractor (DIGITS = 4).
// Cycle k is observed at the falling edge just before rising edge k.
module tb_bcd_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, neg, invalid;
    logic [15:0] diff;

    int total  = 0;
    int passed = 0;

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .neg     (neg),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        neg;
        logic        inv;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Issues one start and follows the operation to its done pulse.
    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [15:0] ed, input logic en, input logic ei, input int lat);
        int cyc;
        int busy_bad;
        bit got;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; busy_bad = 0; got = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (busy !== (cyc < lat)) busy_bad++;
            if (done === 1'b1) got = 1'b1;
        end
        check({nm, " done cycle"}, cyc, lat);
        check({nm, " busy"}, busy_bad, 0);
        check({nm, " diff"}, diff, ed);
        check({nm, " neg"}, neg, en);
        check({nm, " invalid"}, invalid, ei);
        @(negedge clk);
        check({nm, " done pulse width"}, done, 1'b0);
    endtask

    initial begin
        int cyc;
        int bad;
        vecs[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 9};
        vecs[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
        vecs[3] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5};
        vecs[4] = '{16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 5};
        vecs[5] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0, 5};
        vecs[7] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5};
        vecs[8] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 9};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset diff", diff, 16'h0);
        check("reset neg", neg, 1'b0);
        check("reset invalid", invalid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff,
                   vecs[i].neg, vecs[i].inv, vecs[i].lat);
        end

        // Second start in cycle 2 with other operands must be ignored.
        @(negedge clk);
        a = 16'h5432; b = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                a = 16'h0000; b = 16'h9999; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("busy-start done cycle", cyc, 5);
        check("busy-start diff", diff, 16'h4198);
        check("busy-start neg", neg, 1'b0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (diff !== 16'h4198 || neg !== 1'b0 || done !== 1'b0) bad++;
        end
        check("busy-start hold", bad, 0);

        // Leave a negative result, then reset in cycle 2 of the next operation.
        run_op("pre-reset", 16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 9);
        @(negedge clk);
        a = 16'h5432; b = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid busy before reset", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid-reset busy", busy, 1'b0);
        check("mid-reset done", done, 1'b0);
        check("mid-reset diff", diff, 16'h0);
        check("mid-reset neg", neg, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("no done after reset", bad, 0);
        run_op("post-reset", 16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
